// File: rtl/mont_pkg.sv
// Shared types and helpers for the Montgomery domain conversion engine.
// States, mode encodings and the doubling-count function.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic MODE_TO_MONT = 1'b0;
  localparam logic MODE_R2      = 1'b1;

  // Doublings needed: n_len+1 for x*R, twice that for R^2.
  function automatic logic [31:0] calc_k(
    input logic [31:0] n_len,
    input logic        mode
  );
    logic [31:0] base;
    base = n_len + 32'd1;
    return (mode == MODE_R2) ? (base << 1) : base;
  endfunction

endpackage

// File: rtl/mont_dbl_reduce.sv
// One modular doubling step: q = (2r >= n) ? 2r - n : 2r.
// Combinational; r is one bit wider than n so 2r never overflows.
module mont_dbl_reduce #(
  parameter int WIDTH = 2048
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH:0]   q
);

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] n_ext;
  logic [WIDTH:0]   d;

  assign t     = {r, 1'b0};
  assign n_ext = {2'b00, n};
  assign d     = t[WIDTH:0] - {1'b0, n};

  // Subtract n once when the doubled value reaches it.
  always_comb begin
    q = t[WIDTH:0];
    if (t >= n_ext) q = d;
  end

endmodule

// File: rtl/mont_domain_conv.sv
// Montgomery domain conversion: x*R mod n or R^2 mod n, one doubling/clk.
// Optional operand checking is enabled by defining MONT_INPUT_CHECK_EN.
module mont_domain_conv
  import mont_pkg::*;
#(
  parameter int WIDTH = 2048,
  parameter int LEN_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  input  logic [LEN_W-1:0] n_len,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             finish,
  output logic             err
);

  localparam int CNT_W = LEN_W + 2;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] n_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_init;

  mont_dbl_reduce #(
    .WIDTH(WIDTH)
  ) u_dbl (
    .r(r),
    .n(n_q),
    .q(r_nxt)
  );

  assign r_init = (mode == MODE_R2)
                ? {{WIDTH{1'b0}}, 1'b1}
                : {1'b0, x};

`ifdef MONT_INPUT_CHECK_EN
  logic bad;
  logic fail_q;
  logic err_q;

  // Operand validity, evaluated at the start edge.
  always_comb begin
    bad = 1'b0;
    if (!n[0]) bad = 1'b1;
    if (!n[n_len]) bad = 1'b1;
    if (n_len == '0) bad = 1'b1;
    if (mode == MODE_TO_MONT && x >= n) bad = 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      r      <= '0;
      n_q    <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
`ifdef MONT_INPUT_CHECK_EN
      fail_q <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q    <= n;
            r      <= r_init;
            cnt    <= CNT_W'(calc_k(32'(n_len), mode));
            busy   <= 1'b1;
            finish <= 1'b0;
            result <= '0;
`ifdef MONT_INPUT_CHECK_EN
            err_q  <= 1'b0;
            fail_q <= bad;
            if (bad) begin
              r     <= '0;
              state <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state  <= CALC;
`endif
          end
        end
        CALC: begin
          r   <= r_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          result <= r[WIDTH-1:0];
          finish <= 1'b1;
          busy   <= 1'b0;
`ifdef MONT_INPUT_CHECK_EN
          err_q  <= fail_q;
          if (fail_q) result <= '0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_domain_conv.sv
// Directed self-checking bench for mont_domain_conv at WIDTH=16.
// Expectations follow MONT_INPUT_CHECK_EN when it is defined.
module tb_mont_domain_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] x;
  logic [15:0] n;
  logic [3:0]  n_len;
  logic [15:0] result;
  logic        busy;
  logic        finish;
  logic        err;

  int errors = 0;
  int checks = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  mont_domain_conv #(
    .WIDTH(16),
    .LEN_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .x(x),
    .n(n),
    .n_len(n_len),
    .result(result),
    .busy(busy),
    .finish(finish),
    .err(err)
  );

  task automatic start_conv(
    input logic [15:0] xv,
    input logic [15:0] nv,
    input logic [3:0]  lv,
    input logic        mv
  );
    @(negedge clk);
    x = xv; n = nv; n_len = lv; mode = mv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until finish rises; -1 if it never does.
  task automatic wait_finish(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy && finish) both_hi++;
      if (finish) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    x = '0; n = '0; n_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({result, busy, finish, err} !== 19'd0) begin
      errors++;
      $display("FAIL reset: res=%h b=%b f=%b e=%b want 0",
               result, busy, finish, err);
    end
    rst = 1'b1;
  endtask

  task automatic test_to_mont;
    int cyc;
    start_conv(16'h0049, 16'h0109, 4'd8, 1'b0);
    checks++;
    if (busy !== 1'b1 || finish !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: b=%b f=%b want 1 0", busy, finish);
    end
    wait_finish(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL lat_m0: got %0d want 10", cyc);
    end
    checks++;
    if (result !== 16'h000B || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL res_m0: res=%h e=%b b=%b want 000b 0 0",
               result, err, busy);
    end
  endtask

  task automatic test_r2;
    int cyc;
    start_conv(16'h1234, 16'h0109, 4'd8, 1'b1);
    wait_finish(cyc);
    checks++;
    if (cyc !== 19) begin
      errors++;
      $display("FAIL lat_r2: got %0d want 19", cyc);
    end
    checks++;
    if (result !== 16'h003B) begin
      errors++;
      $display("FAIL res_r2: got %h want 003b", result);
    end
  endtask

  task automatic test_full_width;
    int cyc;
    start_conv(16'h0001, 16'hFFF1, 4'd15, 1'b0);
    wait_finish(cyc);
    checks++;
    if (cyc !== 17 || result !== 16'h000F) begin
      errors++;
      $display("FAIL full_x1: lat=%0d res=%h want 17 000f", cyc, result);
    end
    start_conv(16'h0000, 16'hFFF1, 4'd15, 1'b0);
    wait_finish(cyc);
    checks++;
    if (cyc !== 17 || result !== 16'h0000) begin
      errors++;
      $display("FAIL full_x0: lat=%0d res=%h want 17 0000", cyc, result);
    end
    start_conv(16'h0000, 16'hFFF1, 4'd15, 1'b1);
    wait_finish(cyc);
    checks++;
    if (cyc !== 33 || result !== 16'h00E1) begin
      errors++;
      $display("FAIL full_r2: lat=%0d res=%h want 33 00e1", cyc, result);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_conv(16'h0049, 16'h0109, 4'd8, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    x = 16'h0010; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 16'h0001; start = 1'b1;
    wait_finish(cyc);
    checks++;
    if (cyc < 0 || result !== 16'h000B) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d res=%h want 000b", cyc, result);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (finish !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart: f=%b b=%b want 0 1", finish, busy);
    end
    wait_finish(cyc);
    checks++;
    if (cyc !== 10 || result !== 16'h00F7) begin
      errors++;
      $display("FAIL second: lat=%0d res=%h want 10 00f7", cyc, result);
    end
  endtask

  task automatic test_mid_reset;
    int cyc;
    start_conv(16'h0049, 16'h0109, 4'd8, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (busy !== 1'b0 || finish !== 1'b0 || result !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: b=%b f=%b res=%h want 0 0 0000",
               busy, finish, result);
    end
    start_conv(16'h0049, 16'h0109, 4'd8, 1'b0);
    wait_finish(cyc);
    checks++;
    if (cyc !== 10 || result !== 16'h000B) begin
      errors++;
      $display("FAIL post_reset: lat=%0d res=%h want 10 000b", cyc, result);
    end
  endtask

  task automatic test_input_check;
    int cyc;
    start_conv(16'h0049, 16'h0108, 4'd8, 1'b0);
    wait_finish(cyc);
`ifdef MONT_INPUT_CHECK_EN
    checks++;
    if (cyc !== 1 || err !== 1'b1 || result !== 16'h0) begin
      errors++;
      $display("FAIL even_n: lat=%0d e=%b res=%h want 1 1 0000",
               cyc, err, result);
    end
`else
    checks++;
    if (cyc !== 10 || err !== 1'b0) begin
      errors++;
      $display("FAIL even_n: lat=%0d e=%b want 10 0", cyc, err);
    end
`endif
    start_conv(16'h0109, 16'h0109, 4'd8, 1'b0);
    wait_finish(cyc);
`ifdef MONT_INPUT_CHECK_EN
    checks++;
    if (cyc !== 1 || err !== 1'b1 || result !== 16'h0) begin
      errors++;
      $display("FAIL x_ge_n: lat=%0d e=%b res=%h want 1 1 0000",
               cyc, err, result);
    end
`else
    checks++;
    if (cyc !== 10 || err !== 1'b0) begin
      errors++;
      $display("FAIL x_ge_n: lat=%0d e=%b want 10 0", cyc, err);
    end
`endif
    start_conv(16'h0049, 16'h0109, 4'd8, 1'b0);
    wait_finish(cyc);
    checks++;
    if (err !== 1'b0 || result !== 16'h000B) begin
      errors++;
      $display("FAIL err_clear: e=%b res=%h want 0 000b", err, result);
    end
  endtask

  initial begin
    test_reset();
    test_to_mont();
    test_r2();
    test_full_width();
    test_back_to_back();
    test_mid_reset();
    test_input_check();
    checks++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL busy_finish: overlap=%0d want 0", both_hi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_domain_conv.md
# mont_domain_conv

Parametrised Montgomery-domain conversion engine. It computes x·R mod n or R² mod n, where R = 2^(n_len+1), using one modular doubling per clock. It is the width- and mode-generalised successor of the fixed-2048-bit MONT_EXPRESS conversion unit, and feeds operands and the R² constant to the Montgomery multiplier in the RSA datapath. It adds a start handshake, a busy flag, a second mode and optional operand checking.

## Interface
- WIDTH, 2048, operand and modulus width in bits
- LEN_W, $clog2(WIDTH), width of n_len
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0: result = x·R mod n; 1: result = R² mod n (x ignored)
- x  in  WIDTH  operand; precondition x < n
- n  in  WIDTH  modulus; odd, n[n_len] = 1
- n_len  in  LEN_W  MSB index of n; valid range 1..WIDTH-1
- result  out  WIDTH  converted value; held until the next accepted start
- busy  out  1  high while a conversion is in progress
- finish  out  1  level; high from completion until the next accepted start
- err  out  1  invalid-operand flag (see Configuration)

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 captures n, n_len and mode.
  - Loads r ← x (mode 0) or r ← 1 (mode 1).
  - Loads cnt ← k, where k = n_len+1 (mode 0) or 2·(n_len+1) (mode 1).
  - Sets busy=1, clears finish, err and result, then goes to CALC.
- CALC:
  - Each cycle: t = 2r (WIDTH+1 bits); r ← (t ≥ n) ? t − n : t; cnt ← cnt − 1.
  - When cnt = 1, the final doubling is performed and the state goes to DONE.
- DONE: result ← r[WIDTH-1:0], finish ← 1, busy ← 0, then IDLE.
- Invariant: r < n after every step. r is WIDTH+1 bits internally so that 2r cannot overflow.
- start while busy is ignored. start held high in IDLE after completion begins a new conversion.
- Inputs other than start are don't-care after capture.

## Timing
- Reset (rst=0 at an edge): state IDLE; result=0, busy=0, finish=0, err=0; r and cnt cleared. This applies in every state, including mid-CALC. No result is produced, and the aborted request is lost.
- Accepted start at edge E0: busy=1 after E0. Doublings occur at edges E1..Ek. At E(k+1), finish=1 and busy=0.
- Latency from start to finish is k+1 cycles: n_len+2 cycles for mode 0, 2n_len+3 cycles for mode 1.
- busy and finish are never both high.

## Configuration
- MONT_INPUT_CHECK_EN defined:
  - At the accepted start edge, the block checks n[0]=1, n[n_len]=1, n_len ≥ 1, and, in mode 0, x < n.
  - On failure: go directly to DONE. At the next edge, finish=1, err=1, result=0. Latency is 1 cycle.
- MONT_INPUT_CHECK_EN undefined: no checks and no comparator logic; err is tied 0. For invalid operands, result is unspecified, but latency and the handshake are unchanged.

## Structure
- Package mont_pkg holds:
  - the state enum (IDLE/CALC/DONE)
  - the mode encodings MODE_TO_MONT=0 and MODE_R2=1
  - the k-calculation function shared with the multiplier's control
- Sub-module mont_dbl_reduce: combinational, parameter WIDTH. Inputs r and n; output (2r ≥ n) ? 2r − n : 2r. The top instantiates one.

## Test plan
1. WIDTH=16, n=0x0109, n_len=8, x=0x0049, mode 0 → result=0x000B, finish 10 cycles after start, err=0.
2. Same n, mode 1 → result=0x003B (2^18 mod 265), finish 19 cycles after start.
3. Full width: n=0xFFF1, n_len=15, x=0x0001, mode 0 → result=0x000F after 17 cycles. Repeat with x=0 → result=0x0000.
4. Handshake: pulse start during CALC with different x → ignored, and the first result stays correct. Then start held high across finish → the second conversion begins and finish drops.
5. Reset mid-CALC at cycle 4 of scenario 1 → next edge: busy=0, finish=0, result=0. A following start reproduces 0x000B.
6. With MONT_INPUT_CHECK_EN: n=0x0108 (even) or x=0x0109 ≥ n → err=1, result=0, finish 1 cycle after start. Without the macro: err stays 0 and latency equals scenario 1.
